// File: rtl/sprite_blitter.sv
// ============================================================================
// sprite_blitter
// ----------------------------------------------------------------------------
// Purpose:
//   Copies a rectangular 4-bit sprite from a synchronous sprite ROM into the
//   framebuffer, one pixel per non-stalled cycle. Pixels equal to TRANSP are
//   skipped. Each drawn pixel turns into a registered write request
//   (sprite_write / sprite_w_addr / sprite_wdata) for the framebuffer write
//   arbiter.
//
// Parameters:
//   SCREEN_W  framebuffer width in pixels  (default 640)
//   SCREEN_H  framebuffer height in pixels (default 480)
//   TRANSP    transparent pixel value      (default 4'hF)
//
// Ports:
//   Clk            in   1   sole clock, rising edge
//   Reset_n        in   1   asynchronous active-low reset
//   start          in   1   draw request, only looked at in IDLE
//   sprite_x/_y    in   11  signed screen position of the top-left pixel
//   sprite_w/_h    in   7   sprite size, 0..64
//   sprite_base    in   16  ROM word address of the first pixel (row-major)
//   rom_addr       out  16  registered sprite ROM read address
//   rom_data       in   4   ROM pixel, valid one cycle after rom_addr
//   stall          in   1   framebuffer write port busy; freezes the blitter
//   sprite_write   out  1   registered framebuffer write request
//   sprite_w_addr  out  20  registered framebuffer word address
//   sprite_wdata   out  4   registered framebuffer pixel
//   busy           out  1   high whenever the blitter is not in IDLE
//   done           out  1   one-cycle pulse when a draw completes
//
// Configuration:
//   SPRITE_BLITTER_CLIP_EN  when defined, pixels that fall outside the
//                           SCREEN_W x SCREEN_H area are suppressed. When
//                           undefined no clip logic exists, the caller keeps
//                           the sprite on screen and the address is simply
//                           the low 20 bits of y*SCREEN_W + x.
// ============================================================================
module sprite_blitter #(
    parameter int         SCREEN_W = 640,
    parameter int         SCREEN_H = 480,
    parameter logic [3:0] TRANSP   = 4'hF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [10:0] sprite_x,
    input  logic [10:0] sprite_y,
    input  logic [6:0]  sprite_w,
    input  logic [6:0]  sprite_h,
    input  logic [15:0] sprite_base,
    output logic [15:0] rom_addr,
    input  logic [3:0]  rom_data,
    input  logic        stall,
    output logic        sprite_write,
    output logic [19:0] sprite_w_addr,
    output logic [3:0]  sprite_wdata,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      r_state;

    // Draw parameters captured at start so the inputs may change mid-draw.
    logic [10:0] r_x;
    logic [10:0] r_y;
    logic [6:0]  r_w;
    logic [6:0]  r_h;

    // Position of the pixel currently sitting on rom_data.
    logic [5:0]  r_col;
    logic [5:0]  r_row;

    logic [15:0] r_romAddr;
    logic        r_write;
    logic [19:0] r_wAddr;
    logic [3:0]  r_wData;
    logic        r_busy;
    logic        r_done;

    // Holds the pixel owed to the current slot while stall is high.
    logic [3:0]  r_skid;
    logic        r_skidValid;

    logic [3:0]  w_pix;
    logic [12:0] w_posX;
    logic [12:0] w_posY;
    logic [19:0] w_xExt;
    logic [19:0] w_yExt;
    logic [19:0] w_rowBase;
    logic [19:0] w_addr;
    logic        w_colLast;
    logic        w_rowLast;
    logic        w_onScreen;
    logic        w_writeEn;

    // Pixel for this slot: the parked copy after a stall, otherwise the ROM.
    assign w_pix = r_skidValid ? r_skid : rom_data;

    // Screen coordinates of the current pixel, 13-bit two's complement so
    // that sprite positions left of / above the screen stay negative.
    assign w_posX = {{2{r_x[10]}}, r_x} + {7'd0, r_col};
    assign w_posY = {{2{r_y[10]}}, r_y} + {7'd0, r_row};
    assign w_xExt = {{7{w_posX[12]}}, w_posX};
    assign w_yExt = {{7{w_posY[12]}}, w_posY};

    // Row base address. The common 640-wide screen uses 512 + 128 so no
    // multiplier is built; any other width falls back to a constant multiply.
    generate
        if (SCREEN_W == 640) begin : g_shiftAdd
            assign w_rowBase = (w_yExt << 9) + (w_yExt << 7);
        end else begin : g_mult
            assign w_rowBase = w_yExt * 20'(SCREEN_W);
        end
    endgenerate

    assign w_addr = w_rowBase + w_xExt;

    assign w_colLast = ({1'b0, r_col} == (r_w - 7'd1));
    assign w_rowLast = ({1'b0, r_row} == (r_h - 7'd1));

`ifdef SPRITE_BLITTER_CLIP_EN
    // Off screen when either coordinate is negative or past the far edge.
    assign w_onScreen = !w_posX[12] && !w_posY[12] &&
                        (w_posX < 13'(SCREEN_W)) &&
                        (w_posY < 13'(SCREEN_H));
`else
    assign w_onScreen = 1'b1;
`endif

    assign w_writeEn = (w_pix != TRANSP) && w_onScreen;

    // Main control FSM. All outputs are registered here. A stalled cycle
    // freezes every visible register so the arbiter sees the pending write
    // unchanged until it is accepted. DONE takes two cycles: the first shows
    // the last pixel slot, the second carries the done pulse.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_romAddr   <= '0;
            r_write     <= 1'b0;
            r_wAddr     <= '0;
            r_wData     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_skid      <= '0;
            r_skidValid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_x         <= sprite_x;
                        r_y         <= sprite_y;
                        r_w         <= sprite_w;
                        r_h         <= sprite_h;
                        r_col       <= '0;
                        r_row       <= '0;
                        r_romAddr   <= sprite_base;
                        r_skidValid <= 1'b0;
                        r_busy      <= 1'b1;
                        if ((sprite_w == 7'd0) || (sprite_h == 7'd0)) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_PRIME;
                        end
                    end
                end

                ST_PRIME: begin
                    if (!stall) begin
                        r_romAddr <= r_romAddr + 16'd1;
                        r_state   <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (stall) begin
                        // rom_addr is frozen but the ROM still returns the
                        // next word, so park the pixel owed to this slot on
                        // the first stalled edge and replay it on release.
                        if (!r_skidValid) begin
                            r_skid      <= rom_data;
                            r_skidValid <= 1'b1;
                        end
                    end else begin
                        r_skidValid <= 1'b0;
                        r_write     <= w_writeEn;
                        r_wAddr     <= w_addr;
                        r_wData     <= w_pix;
                        r_romAddr   <= r_romAddr + 16'd1;
                        if (w_colLast) begin
                            r_col <= '0;
                            if (w_rowLast) begin
                                r_state <= ST_DONE;
                            end else begin
                                r_row <= r_row + 6'd1;
                            end
                        end else begin
                            r_col <= r_col + 6'd1;
                        end
                    end
                end

                ST_DONE: begin
                    if (!stall) begin
                        if (!r_done) begin
                            r_done  <= 1'b1;
                            r_write <= 1'b0;
                        end else begin
                            r_done  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom_addr      = r_romAddr;
    assign sprite_write  = r_write;
    assign sprite_w_addr = r_wAddr;
    assign sprite_wdata  = r_wData;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_sprite_blitter.sv
// ============================================================================
// tb_sprite_blitter
// ----------------------------------------------------------------------------
// Directed bench for sprite_blitter at its default 640x480 geometry. A small
// synchronous ROM model feeds the blitter, a negedge monitor records every
// accepted framebuffer write and every done pulse, and each scenario compares
// the recorded activity with hand-computed addresses, data and cycle offsets
// measured from the edge that sampled start.
// ============================================================================
module tb_sprite_blitter;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        start;
    logic [10:0] sprite_x;
    logic [10:0] sprite_y;
    logic [6:0]  sprite_w;
    logic [6:0]  sprite_h;
    logic [15:0] sprite_base;
    logic [15:0] rom_addr;
    logic [3:0]  rom_data;
    logic        stall;
    logic        sprite_write;
    logic [19:0] sprite_w_addr;
    logic [3:0]  sprite_wdata;
    logic        busy;
    logic        done;

    logic [3:0]  rom [0:65535];

    int cycle = 0;
    int checks = 0;
    int errors = 0;
    int startCyc;
    int idleCyc;
    int wrAddr[$];
    int wrData[$];
    int wrCyc[$];
    int doneCyc[$];

    sprite_blitter dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .start         (start),
        .sprite_x      (sprite_x),
        .sprite_y      (sprite_y),
        .sprite_w      (sprite_w),
        .sprite_h      (sprite_h),
        .sprite_base   (sprite_base),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .stall         (stall),
        .sprite_write  (sprite_write),
        .sprite_w_addr (sprite_w_addr),
        .sprite_wdata  (sprite_wdata),
        .busy          (busy),
        .done          (done)
    );

    always #5 Clk = ~Clk;

    // Edge counter plus the synchronous sprite ROM.
    always @(posedge Clk) begin
        cycle    <= cycle + 1;
        rom_data <= rom[rom_addr];
    end

    // A write counts as accepted when it is requested and not stalled.
    always @(negedge Clk) begin
        if (sprite_write && !stall) begin
            wrAddr.push_back(int'(sprite_w_addr));
            wrData.push_back(int'(sprite_wdata));
            wrCyc.push_back(cycle);
        end
        if (done) begin
            doneCyc.push_back(cycle);
        end
    end

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qAt(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    task automatic checkWrite(input string tag, input int k, input int expAddr, input int expData);
        checkOutput({tag, "_addr"}, qAt(wrAddr, k), expAddr);
        checkOutput({tag, "_data"}, qAt(wrData, k), expData);
    endtask

    // Presents a draw request for exactly one rising edge; startCyc is the
    // edge that samples it. Returns #1 after that edge.
    task automatic applyStimulus(input logic [10:0] x, input logic [10:0] y,
                                 input logic [6:0] w, input logic [6:0] h,
                                 input logic [15:0] base);
        wrAddr.delete();
        wrData.delete();
        wrCyc.delete();
        doneCyc.delete();
        @(posedge Clk);
        #1;
        sprite_x    = x;
        sprite_y    = y;
        sprite_w    = w;
        sprite_h    = h;
        sprite_base = base;
        start       = 1'b1;
        startCyc    = cycle + 1;
        @(posedge Clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (busy && n < 300);
        idleCyc = cycle;
        if (busy) checkOutput("idle_timeout", 1, 0);
    endtask

    initial begin
        int snap;
        for (int i = 0; i < 65536; i++) rom[i] = 4'h0;
        Reset_n     = 1'b1;
        start       = 1'b0;
        stall       = 1'b0;
        sprite_x    = '0;
        sprite_y    = '0;
        sprite_w    = '0;
        sprite_h    = '0;
        sprite_base = '0;

        // Reset state
        #2 Reset_n = 1'b0;
        #1;
        checkOutput("rst_write", int'(sprite_write), 0);
        checkOutput("rst_waddr", int'(sprite_w_addr), 0);
        checkOutput("rst_wdata", int'(sprite_wdata), 0);
        checkOutput("rst_romaddr", int'(rom_addr), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        repeat (3) @(posedge Clk);
        #2 Reset_n = 1'b1;

        // Basic 2x2 draw at (10,5)
        rom[100] = 4'd1; rom[101] = 4'd2; rom[102] = 4'd3; rom[103] = 4'd4;
        applyStimulus(11'd10, 11'd5, 7'd2, 7'd2, 16'd100);
        waitIdle();
        checkOutput("basic_count", wrAddr.size(), 4);
        checkWrite("basic_w0", 0, 3210, 1);
        checkWrite("basic_w1", 1, 3211, 2);
        checkWrite("basic_w2", 2, 3850, 3);
        checkWrite("basic_w3", 3, 3851, 4);
        checkOutput("basic_first", qAt(wrCyc, 0) - startCyc, 2);
        checkOutput("basic_last", qAt(wrCyc, 3) - startCyc, 5);
        checkOutput("basic_ndone", doneCyc.size(), 1);
        checkOutput("basic_done", qAt(doneCyc, 0) - startCyc, 6);
        checkOutput("basic_idle", idleCyc - startCyc, 7);

        // Transparency: 3x1 with {F,7,F}
        rom[120] = 4'hF; rom[121] = 4'h7; rom[122] = 4'hF;
        applyStimulus(11'd20, 11'd7, 7'd3, 7'd1, 16'd120);
        waitIdle();
        checkOutput("transp_count", wrAddr.size(), 1);
        checkWrite("transp_w0", 0, 4501, 7);
        checkOutput("transp_cyc", qAt(wrCyc, 0) - startCyc, 3);
        checkOutput("transp_done", qAt(doneCyc, 0) - startCyc, 5);
        checkOutput("transp_idle", idleCyc - startCyc, 6);

        // Stall for 4 cycles while the second pixel of a 4x1 sprite waits
        rom[140] = 4'd5; rom[141] = 4'd6; rom[142] = 4'd7; rom[143] = 4'd8;
        applyStimulus(11'd30, 11'd2, 7'd4, 7'd1, 16'd140);
        repeat (3) @(posedge Clk);
        #1 stall = 1'b1;
        repeat (4) @(posedge Clk);
        #1 stall = 1'b0;
        waitIdle();
        checkOutput("stall_count", wrAddr.size(), 4);
        checkWrite("stall_w0", 0, 1310, 5);
        checkWrite("stall_w1", 1, 1311, 6);
        checkWrite("stall_w2", 2, 1312, 7);
        checkWrite("stall_w3", 3, 1313, 8);
        checkOutput("stall_w1cyc", qAt(wrCyc, 1) - startCyc, 7);
        checkOutput("stall_w2cyc", qAt(wrCyc, 2) - startCyc, 8);
        checkOutput("stall_done", qAt(doneCyc, 0) - startCyc, 10);
        checkOutput("stall_idle", idleCyc - startCyc, 11);

        // Zero width
        applyStimulus(11'd50, 11'd50, 7'd0, 7'd3, 16'd0);
        waitIdle();
        checkOutput("zero_count", wrAddr.size(), 0);
        checkOutput("zero_ndone", doneCyc.size(), 1);
        checkOutput("zero_done", qAt(doneCyc, 0) - startCyc, 1);
        checkOutput("zero_idle", idleCyc - startCyc, 2);

        // Start pulses mid-draw and during the done cycle are ignored
        rom[200] = 4'd9; rom[201] = 4'd10; rom[202] = 4'd11; rom[203] = 4'd12;
        applyStimulus(11'd0, 11'd0, 7'd2, 7'd2, 16'd200);
        repeat (2) @(posedge Clk);
        #1;
        sprite_x = 11'd100;
        sprite_w = 7'd5;
        start    = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
        repeat (3) @(posedge Clk);
        #1 start = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
        waitIdle();
        checkOutput("bstart_count", wrAddr.size(), 4);
        checkWrite("bstart_w0", 0, 0, 9);
        checkWrite("bstart_w1", 1, 1, 10);
        checkWrite("bstart_w2", 2, 640, 11);
        checkWrite("bstart_w3", 3, 641, 12);
        checkOutput("bstart_ndone", doneCyc.size(), 1);
        checkOutput("bstart_idle", idleCyc - startCyc, 7);

        // ROM address wraps through 16'hFFFF
        rom[16'hFFFE] = 4'd1; rom[16'hFFFF] = 4'd2; rom[0] = 4'd3; rom[1] = 4'd4;
        applyStimulus(11'd0, 11'd1, 7'd2, 7'd2, 16'hFFFE);
        waitIdle();
        checkOutput("wrap_count", wrAddr.size(), 4);
        checkWrite("wrap_w0", 0, 640, 1);
        checkWrite("wrap_w1", 1, 641, 2);
        checkWrite("wrap_w2", 2, 1280, 3);
        checkWrite("wrap_w3", 3, 1281, 4);
        rom[0] = 4'd0; rom[1] = 4'd0;

`ifdef SPRITE_BLITTER_CLIP_EN
        // 4x4 at (-2,478): only cols 2..3 of rows 0..1 land on screen
        for (int i = 0; i < 16; i++) rom[300 + i] = 4'(i % 15);
        applyStimulus(11'h7FE, 11'd478, 7'd4, 7'd4, 16'd300);
        waitIdle();
        checkOutput("clip_count", wrAddr.size(), 4);
        checkWrite("clip_w0", 0, 305920, 2);
        checkWrite("clip_w1", 1, 305921, 3);
        checkWrite("clip_w2", 2, 306560, 6);
        checkWrite("clip_w3", 3, 306561, 7);
        checkOutput("clip_idle", idleCyc - startCyc, 19);
`else
        // 4x2 tucked into the bottom-right corner, last address 307199
        for (int i = 0; i < 8; i++) rom[400 + i] = 4'(i);
        applyStimulus(11'd636, 11'd478, 7'd4, 7'd2, 16'd400);
        waitIdle();
        checkOutput("corner_count", wrAddr.size(), 8);
        checkWrite("corner_w0", 0, 306556, 0);
        checkWrite("corner_w4", 4, 307196, 4);
        checkWrite("corner_w7", 7, 307199, 7);
        checkOutput("corner_idle", idleCyc - startCyc, 11);
`endif

        // Asynchronous reset in the middle of RUN
        for (int i = 0; i < 16; i++) rom[500 + i] = 4'd1;
        applyStimulus(11'd10, 11'd5, 7'd4, 7'd4, 16'd500);
        repeat (4) @(posedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        checkOutput("arst_write", int'(sprite_write), 0);
        checkOutput("arst_waddr", int'(sprite_w_addr), 0);
        checkOutput("arst_wdata", int'(sprite_wdata), 0);
        checkOutput("arst_romaddr", int'(rom_addr), 0);
        checkOutput("arst_busy", int'(busy), 0);
        snap = wrAddr.size();
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (30) @(negedge Clk);
        checkOutput("arst_nowrites", wrAddr.size() - snap, 0);
        checkOutput("arst_nodone", doneCyc.size(), 0);
        checkOutput("arst_idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
